// File: rtl/alu_defs_pkg.sv
// Shared definitions for the sequenced ALU/register-file datapath:
// opcodes, flag bit positions and FSM state encoding.
package alu_defs_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
  localparam logic [OP_W-1:0] OP_LI   = 4'b1111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_S = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: one operation on A/B (or the immediate for LI)
// producing the result and ZF/CF/OF/SF.
module alu_core
  import alu_defs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [XLEN-1:0]   imm,
  input  logic [OP_W-1:0]   op,
  output logic [XLEN-1:0]   res,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic [XLEN:0]  sum;
  logic [XLEN:0]  diff;
  logic           cf;
  logic           of;
  logic           lt_s;
  logic           lt_u;

  // Extra top bit of sum/diff carries the carry-out / borrow.
  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    res = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[XLEN-1:0];
        cf  = sum[XLEN];
        of  = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        res = diff[XLEN-1:0];
        cf  = diff[XLEN];
        of  = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = XLEN'($signed(a) >>> shamt);
      OP_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_LI:   res = imm;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = cf;
    flags[FLAG_O] = of;
    flags[FLAG_S] = res[XLEN-1];
  end

endmodule

// File: rtl/alu_regfile_seq.sv
// Register file plus 3-state sequencer: accept a command, read two
// registers, execute on alu_core, then optionally write the result back.
module alu_regfile_seq
  import alu_defs_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  input  logic [AW-1:0]     cmd_rd,
  input  logic              cmd_we,
  input  logic [XLEN-1:0]   cmd_imm,
  output logic [XLEN-1:0]   res,
  output logic              res_valid,
  output logic [FLAG_W-1:0] flags,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  state_t            state;
  logic [XLEN-1:0]   rf [NREG];
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   imm_q;
  logic [OP_W-1:0]   op_q;
  logic [AW-1:0]     rd_q;
  logic              we_q;
  logic              valid_q;
  logic [XLEN-1:0]   alu_res;
  logic [FLAG_W-1:0] alu_flags;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .imm   (imm_q),
    .op    (op_q),
    .res   (alu_res),
    .flags (alu_flags)
  );

  // Reset masks the handshake and any in-flight result pulse immediately.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign res_valid = valid_q && !rst;
  assign dbg_data  = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      res     <= '0;
      flags   <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (cmd_valid) begin
            a_q   <= (cmd_ra == '0) ? '0 : rf[cmd_ra];
            b_q   <= (cmd_rb == '0) ? '0 : rf[cmd_rb];
            imm_q <= cmd_imm;
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            we_q  <= cmd_we;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res     <= alu_res;
          flags   <= alu_flags;
          valid_q <= 1'b1;
          state   <= S_WB;
        end
        S_WB: begin
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back on the edge closing WB; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[AW'(i)] <= '0;
      end
    end else if (state == S_WB && we_q && rd_q != '0) begin
      rf[rd_q] <= res;
    end
  end

endmodule

// File: doc/alu_regfile_seq.md
# alu_regfile_seq

Parametrised, self-sequenced successor to the button-clocked ALU-with-register-heap datapath. It runs on a single system clock. Commands are accepted over a valid/ready handshake; each one reads two registers, executes one ALU operation and optionally writes the result back. A 3-state FSM sequences the work, and a combinational debug read port feeds the board-level LED display.

## Interface
Parameters:
- XLEN, 32: data width, ≥8, power of 2
- NREG, 32: register count, power of 2
- AW, $clog2(NREG): register address width (derived)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  ALU operation
- cmd_ra, cmd_rb  in  AW  source register addresses
- cmd_rd  in  AW  destination register address
- cmd_we  in  1  write result to cmd_rd
- cmd_imm  in  XLEN  immediate, used only by LI
- res  out  XLEN  last result, registered
- res_valid  out  1  one-cycle pulse; res and flags are new
- flags  out  4  [0]=ZF, [1]=CF, [2]=OF, [3]=SF; registered
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  combinational rf[dbg_addr]; 0 when dbg_addr==0

## Operation
Register file:
- x0 reads as 0.
- Writes to x0 are dropped.

Opcodes:
- 0000 ADD
- 1000 SUB
- 0001 SLL
- 0101 SRL
- 1101 SRA
- 0010 SLT (signed, result 0/1)
- 0011 SLTU
- 0100 XOR
- 0110 OR
- 0111 AND
- 1111 LI (res = cmd_imm)
- All other codes: res = 0

Arithmetic and width rules:
- Shift amount is B[$clog2(XLEN)-1:0]; upper bits are ignored.
- ADD/SUB are XLEN-bit, modulo 2^XLEN.

Flags:
- ZF = (res==0) and SF = res[XLEN-1], for every op.
- CF: ADD carry-out; SUB borrow (A <u B); 0 otherwise.
- OF: signed overflow for ADD/SUB; 0 otherwise.
- Flags change only when a command completes; they hold otherwise.

FSM states:
- IDLE: cmd_ready=1. On cmd_valid, latch A=rf[ra], B=rf[rb], op, rd, we, imm → EXEC.
- EXEC: compute; register res and flags → WB.
- WB: res_valid=1. If we and rd≠0, write rf[rd]=res at the closing edge → IDLE.

Reset and boundary behaviour:
- Reset values: every register 0, state IDLE, res 0, flags 0, res_valid 0.
- rst has priority over everything. cmd_ready is forced to 0 while rst=1.
- Reset in EXEC or WB aborts the command: no register write, no res_valid.
- cmd_we=0 is compute-only; res and flags still update.

## Timing
- Handshake completes at edge E0 when cmd_valid && cmd_ready.
- res_valid is high in the cycle between E1 and E2.
- The register write lands at E2. cmd_ready rises after E2, so the next command is accepted at E3 at the earliest.
- Throughput is one command per 3 cycles. No bypass is needed: the write at E2 precedes the read at E3.
- Command fields only need to be valid at the handshake edge.
- dbg_data reflects a write from the cycle after the write edge.

## Structure
Shared package alu_defs_pkg holds:
- opcode constants
- flag bit indices (FLAG_Z, FLAG_C, FLAG_O, FLAG_S)
- FSM state encoding (S_IDLE, S_EXEC, S_WB)

Sub-module alu_core (combinational):
- inputs: A, B, imm, op
- outputs: res, flags
- parametrised by XLEN

The register file and FSM live in alu_regfile_seq.

## Test plan
- Reset, then sweep dbg_addr 0..NREG-1 → dbg_data all 0; cmd_ready=1, res_valid=0, flags=0000.
- LI x1=0x7FFFFFFF, LI x2=1, then ADD x3=x1+x2 → res=0x80000000, flags SF=1, OF=1, CF=0, ZF=0; res_valid pulses 2 cycles after accept; dbg x3=0x80000000.
- SUB x0=x2-x2 with cmd_we=1 → res=0, ZF=1, CF=0; dbg x0 stays 0. SUB x4=x0-x2 → res=0xFFFFFFFF, CF=1, SF=1.
- LI x5=0x80000000, LI x7=33, SRA x6=x5>>x7 → res=0xC0000000 (shamt 1). SRL with the same operands → 0x40000000. SLT x5,x2 → 1; SLTU x5,x2 → 0.
- cmd_valid held high with dependent ADDs x8=x2+x2, then x8=x8+x8 → accepts exactly 3 cycles apart; second res=4.
- Accept ADD x9 (we=1), assert rst for one cycle during EXEC → no res_valid, x9 stays 0, flags=0; cmd_ready=1 the cycle after rst deasserts.
